digital_clock_12h: RTL and testbench

- 12-hour BCD time-of-day counter (HH:MM:SS with AM/PM flag) plus a single HH:MM alarm comparator.
- Sits between a one-second tick source (internal prescaler off the system clock) and a six-digit 7-segment display driver.
- One input port, r_time, is multiplexed: it is the time-set value in set mode and the alarm time in run mode.

---
 rtl/digital_clock_12h.sv | 186 ++++++++++++++++++
 tb/tb_digital_clock_12h.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/digital_clock_12h.sv
// digital_clock_12h: 12-hour BCD HH:MM:SS counter with AM/PM and HH:MM alarm.
// Define ALARM_SNOOZE_EN to add a snooze input that mutes the current match.
module digital_clock_12h #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        r_m,
  input  logic [15:0] r_time,
`ifdef ALARM_SNOOZE_EN
  input  logic        snooze,
`endif
  output logic [3:0]  q1,
  output logic [3:0]  q2,
  output logic [3:0]  q3,
  output logic [3:0]  q4,
  output logic [3:0]  q5,
  output logic [3:0]  q6,
  output logic        am,
  output logic        alarm
);

  localparam int unsigned PW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [3:0] sec_lo_q, sec_lo_d;
  logic [3:0] sec_hi_q, sec_hi_d;
  logic [3:0] min_lo_q, min_lo_d;
  logic [3:0] min_hi_q, min_hi_d;
  logic [3:0] hr_lo_q, hr_lo_d;
  logic [3:0] hr_hi_q, hr_hi_d;
  logic       am_q, am_d;
  logic       alarm_q, alarm_d;
  logic       rm_q, rm_d;

  logic hr_ok;
  logic ld_ok;
  logic tick;
  logic match;
  logic mute;

  always_comb begin
    hr_ok = 1'b0;
    case (r_time[15:12])
      4'd0:    hr_ok = (r_time[11:8] >= 4'd1) &&
                       (r_time[11:8] <= 4'd9);
      4'd1:    hr_ok = (r_time[11:8] <= 4'd2);
      default: hr_ok = 1'b0;
    endcase
    ld_ok = hr_ok &&
            (r_time[7:4] <= 4'd5) &&
            (r_time[3:0] <= 4'd9);
  end

  assign match = ({hr_hi_q, hr_lo_q, min_hi_q, min_lo_q}
                  == r_time);

`ifdef ALARM_SNOOZE_EN
  logic snz_q, snz_d;

  // Snooze latches until the displayed HH:MM leaves the alarm minute.
  always_comb begin
    snz_d = match && (snz_q || snooze);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      snz_q <= 1'b0;
    end else begin
      snz_q <= snz_d;
    end
  end

  assign mute = snz_q || snooze;
`else
  assign mute = 1'b0;
`endif

  always_comb begin
    pre_d    = pre_q;
    sec_lo_d = sec_lo_q;
    sec_hi_d = sec_hi_q;
    min_lo_d = min_lo_q;
    min_hi_d = min_hi_q;
    hr_lo_d  = hr_lo_q;
    hr_hi_d  = hr_hi_q;
    am_d     = am_q;
    tick     = 1'b0;
    rm_d     = r_m;
    alarm_d  = !r_m && !rm_q && match && !mute;

    if (r_m) begin
      if (ld_ok) begin
        hr_hi_d  = r_time[15:12];
        hr_lo_d  = r_time[11:8];
        min_hi_d = r_time[7:4];
        min_lo_d = r_time[3:0];
        sec_hi_d = 4'd0;
        sec_lo_d = 4'd0;
        pre_d    = '0;
      end
    end else if (enable) begin
      if (pre_q == PRE_MAX) begin
        pre_d = '0;
        tick  = 1'b1;
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end

    if (tick) begin
      if (sec_lo_q != 4'd9) begin
        sec_lo_d = sec_lo_q + 4'd1;
      end else begin
        sec_lo_d = 4'd0;
        if (sec_hi_q != 4'd5) begin
          sec_hi_d = sec_hi_q + 4'd1;
        end else begin
          sec_hi_d = 4'd0;
          if (min_lo_q != 4'd9) begin
            min_lo_d = min_lo_q + 4'd1;
          end else begin
            min_lo_d = 4'd0;
            if (min_hi_q != 4'd5) begin
              min_hi_d = min_hi_q + 4'd1;
            end else begin
              min_hi_d = 4'd0;
              // Hours run 12, 01..11; 11 -> 12 flips the meridiem.
              if (hr_hi_q == 4'd1 && hr_lo_q == 4'd2) begin
                hr_hi_d = 4'd0;
                hr_lo_d = 4'd1;
              end else if (hr_lo_q == 4'd9) begin
                hr_hi_d = 4'd1;
                hr_lo_d = 4'd0;
              end else begin
                hr_lo_d = hr_lo_q + 4'd1;
              end
              if (hr_hi_q == 4'd1 && hr_lo_q == 4'd1) begin
                am_d = !am_q;
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pre_q    <= '0;
      sec_lo_q <= 4'd0;
      sec_hi_q <= 4'd0;
      min_lo_q <= 4'd0;
      min_hi_q <= 4'd0;
      hr_lo_q  <= 4'd2;
      hr_hi_q  <= 4'd1;
      am_q     <= 1'b1;
      alarm_q  <= 1'b0;
      rm_q     <= 1'b0;
    end else begin
      pre_q    <= pre_d;
      sec_lo_q <= sec_lo_d;
      sec_hi_q <= sec_hi_d;
      min_lo_q <= min_lo_d;
      min_hi_q <= min_hi_d;
      hr_lo_q  <= hr_lo_d;
      hr_hi_q  <= hr_hi_d;
      am_q     <= am_d;
      alarm_q  <= alarm_d;
      rm_q     <= rm_d;
    end
  end

  assign q1    = sec_lo_q;
  assign q2    = sec_hi_q;
  assign q3    = min_lo_q;
  assign q4    = min_hi_q;
  assign q5    = hr_lo_q;
  assign q6    = hr_hi_q;
  assign am    = am_q;
  assign alarm = alarm_q;

endmodule

// File: tb/tb_digital_clock_12h.sv
// tb_digital_clock_12h: randomized check of digital_clock_12h
// against a seconds-of-day reference model.
module tb_digital_clock_12h;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        r_m;
  logic [15:0] r_time;
`ifdef ALARM_SNOOZE_EN
  logic        snooze;
`endif
  logic [3:0]  q1, q2, q3, q4, q5, q6;
  logic        am;
  logic        alarm;

  int n_checks = 0;
  int n_errors = 0;

  // Model: t = seconds since 12:00:00 AM (0..86399).
  int m_t   = 0;
  bit m_al  = 1'b0;
  bit m_rmp = 1'b0;
  bit m_snz = 1'b0;

  digital_clock_12h #(.TICK_DIV(1)) dut (
    .clock (clock),
    .reset (reset),
    .enable(enable),
    .r_m   (r_m),
    .r_time(r_time),
`ifdef ALARM_SNOOZE_EN
    .snooze(snooze),
`endif
    .q1    (q1),
    .q2    (q2),
    .q3    (q3),
    .q4    (q4),
    .q5    (q5),
    .q6    (q6),
    .am    (am),
    .alarm (alarm)
  );

  always #5 clock = ~clock;

  task automatic check_eq(string tag, logic [31:0] got,
                          logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int hour12(int t);
    int h;
    h = (t / 3600) % 12;
    return (h == 0) ? 12 : h;
  endfunction

  function automatic logic [15:0] bcd_hm(int t);
    int h, m;
    h = hour12(t);
    m = (t / 60) % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  function automatic logic [23:0] bcd_full(int t);
    int s;
    s = t % 60;
    return {bcd_hm(t), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [15:0] hm_to_bcd(int h, int m);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
  endfunction

  task automatic step();
    int nt, ht, ho, mt, mo, h;
    bit nal, nsnz, match, sz, valid;
    nt = m_t;
    nal = 1'b0;
    nsnz = 1'b0;
    sz = 1'b0;
`ifdef ALARM_SNOOZE_EN
    sz = snooze;
`endif
    if (!reset) begin
      nt = 0;
    end else begin
      match = (bcd_hm(m_t) == r_time);
      nal  = !r_m && !m_rmp && match && !m_snz && !sz;
`ifdef ALARM_SNOOZE_EN
      nsnz = match && (m_snz || sz);
`endif
      if (r_m) begin
        ht = int'(r_time[15:12]);
        ho = int'(r_time[11:8]);
        mt = int'(r_time[7:4]);
        mo = int'(r_time[3:0]);
        h  = ht * 10 + ho;
        valid = ho <= 9 && mt <= 5 && mo <= 9 &&
                h >= 1 && h <= 12;
        if (valid) begin
          nt = ((h % 12) + ((m_t < 43200) ? 0 : 12)) * 3600
               + (mt * 10 + mo) * 60;
        end
      end else if (enable) begin
        nt = (m_t + 1) % 86400;
      end
    end
    @(posedge clock);
    #1;
    m_t   = nt;
    m_al  = nal;
    m_snz = nsnz;
    m_rmp = reset ? r_m : 1'b0;
    check_eq("time", 32'({q6, q5, q4, q3, q2, q1}),
             32'(bcd_full(m_t)));
    check_eq("am", 32'(am), 32'(m_t < 43200));
    check_eq("alarm", 32'(alarm), 32'(m_al));
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [23:0] dut_time();
    return {q6, q5, q4, q3, q2, q1};
  endfunction

  initial begin
    int h, m, sel;
    reset  = 1'b0;
    enable = 1'b1;
    r_m    = 1'b0;
    r_time = 16'h0000;
`ifdef ALARM_SNOOZE_EN
    snooze = 1'b0;
`endif
    steps(2);
    check_eq("rst_time", 32'(dut_time()), 32'h120000);
    check_eq("rst_am", 32'(am), 32'd1);
    check_eq("rst_alarm", 32'(alarm), 32'd0);

    reset = 1'b1;
    steps(60);
    check_eq("cnt_60", 32'(dut_time()), 32'h120100);
    steps(3540);
    check_eq("cnt_3600", 32'(dut_time()), 32'h010000);
    check_eq("cnt_am", 32'(am), 32'd1);

    r_m = 1'b1;
    r_time = 16'h1159;
    step();
    check_eq("ld_1159", 32'(dut_time()), 32'h115900);
    r_m = 1'b0;
    r_time = 16'h0000;
    steps(60);
    check_eq("roll_time", 32'(dut_time()), 32'h120000);
    check_eq("roll_pm", 32'(am), 32'd0);
    steps(43200);
    check_eq("roll_am", 32'(am), 32'd1);

    r_m = 1'b1;
    r_time = 16'h1210;
    step();
    check_eq("set_1210", 32'(dut_time()), 32'h121000);
    r_time = 16'h1360;
    step();
    check_eq("set_bad", 32'(dut_time()), 32'h121000);
    r_m = 1'b0;
    enable = 1'b0;
    steps(10);
    check_eq("frozen", 32'(dut_time()), 32'h121000);
    enable = 1'b1;

    r_m = 1'b1;
    r_time = 16'h1209;
    step();
    r_m = 1'b0;
    r_time = 16'h1210;
    steps(60);
    check_eq("al_t0", 32'(dut_time()), 32'h121000);
    check_eq("al_pre", 32'(alarm), 32'd0);
    step();
    check_eq("al_rise", 32'(alarm), 32'd1);
    steps(9);
`ifdef ALARM_SNOOZE_EN
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    check_eq("snz_clr", 32'(alarm), 32'd0);
    steps(48);
    check_eq("snz_hold", 32'(alarm), 32'd0);
`else
    steps(49);
    check_eq("al_hold", 32'(alarm), 32'd1);
`endif
    steps(2);
    check_eq("al_t1", 32'(dut_time()), 32'h121101);
    check_eq("al_fall", 32'(alarm), 32'd0);

    for (int i = 0; i < 4000; i++) begin
      reset  = ($urandom_range(0, 199) != 0);
      r_m    = ($urandom_range(0, 9) == 0);
      enable = ($urandom_range(0, 7) != 0);
`ifdef ALARM_SNOOZE_EN
      snooze = ($urandom_range(0, 19) == 0);
`endif
      if ($urandom_range(0, 15) == 0) begin
        sel = int'($urandom_range(0, 3));
        h = int'($urandom_range(1, 12));
        m = int'($urandom_range(0, 59));
        if (sel == 0) r_time = 16'($urandom);
        else if (sel == 1) r_time = hm_to_bcd(h, m);
        else r_time = bcd_hm(m_t);
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
